// File: rtl/branch_tag_alloc_if.sv
// Branch-tag allocator bus. Groups the flush, allocation, resolution and
// status signals so that the fetch side and the allocator share one port.
//
// master : fetch/predecode side (drives flush, alloc_req, res_*)
// slave  : branch_tag_alloc (drives grant, tags, masks and status)
//
//   flush       full pipeline flush
//   alloc_req   per-lane allocation request, prefix-contiguous from lane 0
//   alloc_gnt   all requesting lanes granted this cycle
//   stall       request present but not granted
//   alloc_tag   tag assigned to each lane
//   alloc_mask  older-unresolved-branch mask for each lane
//   res_valid   resolution broadcast valid
//   res_kill    1 = mispredict, 0 = correct
//   res_tag     resolved tag
//   live_mask   allocated, unresolved tags
//   free_count  number of free tags
//   err         sticky protocol error
interface branch_tag_alloc_if #(
    parameter int unsigned NUM_TAGS    = 8,
    parameter int unsigned ALLOC_WIDTH = 2
);
    localparam int unsigned TAG_W = $clog2(NUM_TAGS);

    logic                                  flush;
    logic [ALLOC_WIDTH-1:0]                alloc_req;
    logic                                  alloc_gnt;
    logic                                  stall;
    logic [ALLOC_WIDTH-1:0][TAG_W-1:0]     alloc_tag;
    logic [ALLOC_WIDTH-1:0][NUM_TAGS-1:0]  alloc_mask;
    logic                                  res_valid;
    logic                                  res_kill;
    logic [TAG_W-1:0]                      res_tag;
    logic [NUM_TAGS-1:0]                   live_mask;
    logic [TAG_W:0]                        free_count;
    logic                                  err;

    modport master (
        output flush, alloc_req, res_valid, res_kill, res_tag,
        input  alloc_gnt, stall, alloc_tag, alloc_mask, live_mask, free_count, err
    );

    modport slave (
        input  flush, alloc_req, res_valid, res_kill, res_tag,
        output alloc_gnt, stall, alloc_tag, alloc_mask, live_mask, free_count, err
    );
endinterface

// File: rtl/branch_tag_alloc.sv
// Branch-tag and branch-mask manager for the fetch frontend.
//
// Allocates up to ALLOC_WIDTH tags per cycle from a pool of NUM_TAGS, hands
// each new branch the mask of older unresolved branches, and keeps a mask
// snapshot per tag so that a kill restores the live mask directly.
//
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  branch_tag_alloc_if.slave (allocation, resolution and status)
//
// All bus outputs are combinational from state and inputs except err.
module branch_tag_alloc #(
    parameter int unsigned NUM_TAGS    = 8,
    parameter int unsigned ALLOC_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    branch_tag_alloc_if.slave  bus
);
    localparam int unsigned TAG_W = $clog2(NUM_TAGS);

    logic [NUM_TAGS-1:0]                  live_q, live_d;
    logic [NUM_TAGS-1:0][NUM_TAGS-1:0]    snap_q, snap_d;
    logic                                 err_q, err_d;

    logic                                 res_hit;
    logic                                 kill;
    logic                                 clean;
    logic [NUM_TAGS-1:0]                  clean_bit;
    logic [NUM_TAGS-1:0]                  eff;
    logic                                 req_prefix;
    logic                                 gnt;
    int                                   req_cnt;
    int                                   free_cnt;
    logic [ALLOC_WIDTH-1:0][TAG_W-1:0]    lane_tag;
    logic [ALLOC_WIDTH-1:0][NUM_TAGS-1:0] lane_mask;

    // Resolution decode; a broadcast on a tag that is not live has no effect.
    assign res_hit = bus.res_valid & live_q[bus.res_tag];
    assign kill    = res_hit & bus.res_kill;
    assign clean   = res_hit & ~bus.res_kill;

    always_comb begin
        clean_bit = '0;
        if (clean) begin
            clean_bit[bus.res_tag] = 1'b1;
        end
    end

    assign eff = live_q & ~clean_bit;

    // Request shape: every set lane must have its lower neighbour set.
    always_comb begin
        req_prefix = 1'b1;
        req_cnt    = 0;
        for (int i = 0; i < int'(ALLOC_WIDTH); i++) begin
            if (bus.alloc_req[i]) begin
                req_cnt = req_cnt + 1;
                if (i > 0 && !bus.alloc_req[i-1]) begin
                    req_prefix = 1'b0;
                end
            end
        end
    end

    // Lane i takes the i-th lowest free tag. Free tags come from live_q, not
    // eff, so a tag cleaned this cycle is only reusable from the next cycle.
    always_comb begin
        lane_tag = '0;
        free_cnt = 0;
        for (int j = 0; j < int'(NUM_TAGS); j++) begin
            if (!live_q[j]) begin
                for (int i = 0; i < int'(ALLOC_WIDTH); i++) begin
                    if (free_cnt == i) begin
                        lane_tag[i] = TAG_W'(j);
                    end
                end
                free_cnt = free_cnt + 1;
            end
        end
    end

    // Each lane depends on all older live branches plus the lanes before it.
    always_comb begin
        logic [NUM_TAGS-1:0] acc;
        acc       = eff;
        lane_mask = '0;
        for (int i = 0; i < int'(ALLOC_WIDTH); i++) begin
            lane_mask[i] = acc;
            acc          = acc | (NUM_TAGS'(1) << lane_tag[i]);
        end
    end

    assign gnt = (req_cnt > 0) && (free_cnt >= req_cnt) && req_prefix && !kill && !bus.flush;

    always_comb begin
        live_d = live_q;
        snap_d = snap_q;
        if (bus.flush) begin
            live_d = '0;
            snap_d = '0;
        end else if (kill) begin
            // The snapshot holds exactly the branches older than the killed one.
            live_d = snap_q[bus.res_tag];
        end else begin
            if (clean) begin
                live_d = eff;
                for (int j = 0; j < int'(NUM_TAGS); j++) begin
                    snap_d[j] = snap_q[j] & ~clean_bit;
                end
            end
            if (gnt) begin
                for (int i = 0; i < int'(ALLOC_WIDTH); i++) begin
                    if (bus.alloc_req[i]) begin
                        live_d[lane_tag[i]] = 1'b1;
                        snap_d[lane_tag[i]] = lane_mask[i];
                    end
                end
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (!bus.flush) begin
            if ((bus.res_valid && !live_q[bus.res_tag]) || !req_prefix) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q <= '0;
            snap_q <= '0;
            err_q  <= 1'b0;
        end else begin
            live_q <= live_d;
            snap_q <= snap_d;
            err_q  <= err_d;
        end
    end

    assign bus.alloc_gnt  = gnt;
    assign bus.stall      = (|bus.alloc_req) & ~gnt;
    assign bus.alloc_tag  = lane_tag;
    assign bus.alloc_mask = lane_mask;
    assign bus.live_mask  = live_q;
    assign bus.free_count = (TAG_W+1)'(free_cnt);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_branch_tag_alloc.sv
module tb_branch_tag_alloc;
    localparam int NT = 4;
    localparam int AW = 2;
    localparam int TW = 2;
    localparam int NVEC = 18;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_tag_alloc_if #(.NUM_TAGS(NT), .ALLOC_WIDTH(AW)) bus ();
    branch_tag_alloc #(.NUM_TAGS(NT), .ALLOC_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic [AW-1:0] r, input logic v, input logic k,
                         input logic [TW-1:0] t);
        bus.flush     = f;
        bus.alloc_req = r;
        bus.res_valid = v;
        bus.res_kill  = k;
        bus.res_tag   = t;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          flush;
        logic [AW-1:0] req;
        logic          rv;
        logic          rk;
        logic [TW-1:0] rt;
        logic          gnt;
        logic          stall;
        logic [1:0]    chk;
        logic [TW-1:0] t0;
        logic [TW-1:0] t1;
        logic [NT-1:0] m0;
        logic [NT-1:0] m1;
        logic [NT-1:0] live;
        logic [2:0]    free;
        logic          err;
    } vec_t;

    vec_t vecs[NVEC];

    // Reference model: unresolved tags kept oldest-first.
    int order[$];
    bit merr;

    function automatic logic [NT-1:0] order_bits();
        logic [NT-1:0] b;
        b = '0;
        foreach (order[i]) b[order[i]] = 1'b1;
        return b;
    endfunction

    initial begin
        //          fl    req    rv    rk    rt     gnt   stl   chk    t0     t1     m0       m1       live     free  err
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 3'd4, 1'b0};
        vecs[1]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b11, 2'd0, 2'd1, 4'b0000, 4'b0001, 4'b0000, 3'd4, 1'b0};
        vecs[2]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b11, 2'd2, 2'd3, 4'b0011, 4'b0111, 4'b0011, 3'd2, 1'b0};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b1111, 3'd0, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b1111, 3'd0, 1'b0};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'b01, 2'd2, 2'd0, 4'b0001, 4'b0000, 4'b0011, 3'd2, 1'b0};
        vecs[6]  = '{1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b0101, 3'd2, 1'b0};
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b11, 2'd0, 2'd1, 4'b0000, 4'b0001, 4'b0000, 3'd4, 1'b0};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b11, 2'd2, 2'd3, 4'b0011, 4'b0111, 4'b0011, 3'd2, 1'b0};
        vecs[9]  = '{1'b0, 2'b11, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 2'b00, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b1111, 3'd0, 1'b0};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b01, 2'd1, 2'd0, 4'b0001, 4'b0000, 4'b0001, 3'd3, 1'b0};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b0011, 3'd2, 1'b0};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b0001, 3'd3, 1'b0};
        vecs[13] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b0001, 3'd3, 1'b1};
        vecs[14] = '{1'b0, 2'b10, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b0001, 3'd3, 1'b1};
        vecs[15] = '{1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b11, 2'd1, 2'd2, 4'b0001, 4'b0011, 4'b0001, 3'd3, 1'b1};
        vecs[16] = '{1'b1, 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b0111, 3'd1, 1'b1};
        vecs[17] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 3'd4, 1'b1};

        rst = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table, one row per cycle.
        for (int k = 0; k < NVEC; k++) begin
            drive(vecs[k].flush, vecs[k].req, vecs[k].rv, vecs[k].rk, vecs[k].rt);
            #4;
            check($sformatf("v%0d gnt", k), 32'(bus.alloc_gnt), 32'(vecs[k].gnt));
            check($sformatf("v%0d stall", k), 32'(bus.stall), 32'(vecs[k].stall));
            check($sformatf("v%0d live", k), 32'(bus.live_mask), 32'(vecs[k].live));
            check($sformatf("v%0d free", k), 32'(bus.free_count), 32'(vecs[k].free));
            check($sformatf("v%0d err", k), 32'(bus.err), 32'(vecs[k].err));
            if (vecs[k].chk[0]) begin
                check($sformatf("v%0d tag0", k), 32'(bus.alloc_tag[0]), 32'(vecs[k].t0));
                check($sformatf("v%0d mask0", k), 32'(bus.alloc_mask[0]), 32'(vecs[k].m0));
            end
            if (vecs[k].chk[1]) begin
                check($sformatf("v%0d tag1", k), 32'(bus.alloc_tag[1]), 32'(vecs[k].t1));
                check($sformatf("v%0d mask1", k), 32'(bus.alloc_mask[1]), 32'(vecs[k].m1));
            end
            next_cycle();
        end

        // rst clears the sticky error; a non-prefix request sets it again.
        rst = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 2'd0);
        next_cycle();
        rst = 1'b0;
        #4;
        check("rst err", 32'(bus.err), 32'd0);
        check("rst live", 32'(bus.live_mask), 32'd0);
        check("rst free", 32'(bus.free_count), 32'd4);
        check("rst gnt", 32'(bus.alloc_gnt), 32'd0);
        check("rst stall", 32'(bus.stall), 32'd0);
        next_cycle();
        drive(1'b0, 2'b10, 1'b0, 1'b0, 2'd0);
        #4;
        check("nonprefix gnt", 32'(bus.alloc_gnt), 32'd0);
        check("nonprefix stall", 32'(bus.stall), 32'd1);
        next_cycle();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 2'd0);
        #4;
        check("nonprefix err", 32'(bus.err), 32'd1);
        check("nonprefix live", 32'(bus.live_mask), 32'd0);

        // Clean + dual grant in one edge; the new snapshot must exclude the
        // cleaned tag, which a later kill makes visible.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 2'b11, 1'b0, 1'b0, 2'd0);
        #4;
        check("seq gnt a", 32'(bus.alloc_gnt), 32'd1);
        next_cycle();
        drive(1'b0, 2'b11, 1'b1, 1'b0, 2'd0);
        #4;
        check("seq gnt b", 32'(bus.alloc_gnt), 32'd1);
        check("seq tag0", 32'(bus.alloc_tag[0]), 32'd2);
        check("seq tag1", 32'(bus.alloc_tag[1]), 32'd3);
        check("seq mask0", 32'(bus.alloc_mask[0]), 32'b0010);
        check("seq mask1", 32'(bus.alloc_mask[1]), 32'b0110);
        next_cycle();
        drive(1'b0, 2'b00, 1'b1, 1'b1, 2'd2);
        #4;
        check("seq live b", 32'(bus.live_mask), 32'b1110);
        next_cycle();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 2'd0);
        #4;
        check("seq live kill", 32'(bus.live_mask), 32'b0010);
        check("seq free kill", 32'(bus.free_count), 32'd3);
        check("seq err", 32'(bus.err), 32'd0);

        // Randomised phase against the ordered-list model.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        order.delete();
        merr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic          f, v, k, ok, kl, cl, eg;
            logic [AW-1:0] r;
            logic [TW-1:0] t;
            logic [NT-1:0] eff, acc;
            int            sel, pos, n;
            int            fl[$];

            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                drive(1'b0, 2'b00, 1'b0, 1'b0, 2'd0);
                next_cycle();
                rst = 1'b0;
                order.delete();
                merr = 1'b0;
                continue;
            end

            f   = ($urandom_range(0, 39) == 0);
            sel = $urandom_range(0, 199);
            if (sel == 0)       r = 2'b10;
            else if (sel < 60)  r = 2'b00;
            else if (sel < 130) r = 2'b01;
            else                r = 2'b11;
            v = ($urandom_range(0, 1) == 1);
            k = ($urandom_range(0, 3) == 0);
            if (order.size() > 0 && $urandom_range(0, 7) != 0)
                t = TW'(order[$urandom_range(0, order.size() - 1)]);
            else
                t = TW'($urandom_range(0, NT - 1));

            pos = -1;
            foreach (order[i]) if (order[i] == int'(t)) pos = i;
            kl = v && (pos >= 0) && k;
            cl = v && (pos >= 0) && !k;
            ok = 1'b1;
            n  = 0;
            for (int i = 0; i < AW; i++) begin
                if (r[i]) begin
                    n++;
                    if (i > 0 && !r[i-1]) ok = 1'b0;
                end
            end
            fl.delete();
            for (int j = 0; j < NT; j++) if (!order_bits()[j]) fl.push_back(j);
            eg  = !f && !kl && ok && (n > 0) && (fl.size() >= n);
            eff = order_bits();
            if (cl) eff[t] = 1'b0;

            drive(f, r, v, k, t);
            #4;
            check($sformatf("r%0d gnt", c), 32'(bus.alloc_gnt), 32'(eg));
            check($sformatf("r%0d stall", c), 32'(bus.stall), 32'((n > 0) && !eg));
            check($sformatf("r%0d live", c), 32'(bus.live_mask), 32'(order_bits()));
            check($sformatf("r%0d free", c), 32'(bus.free_count), 32'(NT - order.size()));
            check($sformatf("r%0d err", c), 32'(bus.err), 32'(merr));
            if (eg) begin
                acc = eff;
                for (int i = 0; i < n; i++) begin
                    check($sformatf("r%0d tag%0d", c, i), 32'(bus.alloc_tag[i]), 32'(fl[i]));
                    check($sformatf("r%0d mask%0d", c, i), 32'(bus.alloc_mask[i]), 32'(acc));
                    acc[fl[i]] = 1'b1;
                end
            end

            if (f) begin
                order.delete();
            end else if (kl) begin
                while (order.size() > pos) void'(order.pop_back());
            end else begin
                if (cl) order.delete(pos);
                if (eg) for (int i = 0; i < n; i++) order.push_back(fl[i]);
            end
            if (!f && ((v && pos < 0) || !ok)) merr = 1'b1;
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
